// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
//   - Controller state type (IDLE/EXEC/WAIT/HOLD).
//   - ALU opcode constants used by the decode stage and the ALU.
//   - Width of the multi-cycle hold counter and its preload helper.
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_CTRL_IDLE = 2'd0,
    ALU_CTRL_EXEC = 2'd1,
    ALU_CTRL_WAIT = 2'd2,
    ALU_CTRL_HOLD = 2'd3
  } alu_ctrl_state_e;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADC  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_ASL  = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_DJNZ = 6'h06;

  // Counter holds MCP_CYCLES-2, at most 6 for the legal range 2..8.
  localparam int unsigned MCP_CNT_W = 3;

  function automatic logic [MCP_CNT_W-1:0] mcp_preload(input int unsigned mcp_cycles);
    return MCP_CNT_W'(mcp_cycles - 2);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Sequencing controller between decode and the combinational ALU.
// Accepts one op over issue_valid/issue_ready, registers opcode/operands to
// drive the ALU, holds them while the ALU requests a multi-cycle evaluation,
// captures result/flags and presents the result over res_valid/res_ready.
// Owns the architectural C/V flags that feed the ALU carry/overflow inputs.
// Ports:
//   clk, reset_b                       clock, async active-low reset
//   issue_*                            operation handshake and payload
//   flush                              synchronous abort of the in-flight op
//   flags_wr, flags_wr_c, flags_wr_v   direct C/V load
//   alu_opcode/a/b/cin/vin             to ALU
//   alu_dout/cout/vout/qnz/mcp         from ALU
//   res_valid/ready/data/qnz           result handshake
//   flag_c, flag_v, busy               status
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned OPW        = 6,
  parameter int unsigned MCP_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           issue_valid,
  output logic           issue_ready,
  input  logic [OPW-1:0] issue_opcode,
  input  logic [DW-1:0]  issue_a,
  input  logic [DW-1:0]  issue_b,
  input  logic           issue_wr_flags,
  input  logic           flush,
  input  logic           flags_wr,
  input  logic           flags_wr_c,
  input  logic           flags_wr_v,
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic           alu_cin,
  output logic           alu_vin,
  input  logic [DW-1:0]  alu_dout,
  input  logic           alu_cout,
  input  logic           alu_vout,
  input  logic           alu_qnz,
  input  logic           alu_mcp,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic           res_qnz,
  output logic           flag_c,
  output logic           flag_v,
  output logic           busy
);

  alu_ctrl_state_e       state_q, state_d;
  logic [MCP_CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0]        op_q;
  logic [DW-1:0]         a_q, b_q;
  logic                  wrf_q;
  logic [DW-1:0]         res_data_q;
  logic                  res_qnz_q;
  logic                  flag_c_q, flag_v_q;
  logic                  accept;
  logic                  capture;

  // HOLD releases its result and takes a new op on the same edge.
  assign issue_ready = ~flush &
                       ((state_q == ALU_CTRL_IDLE) |
                        ((state_q == ALU_CTRL_HOLD) & res_ready));
  assign accept      = issue_valid & issue_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ALU_CTRL_IDLE: begin
        if (accept) state_d = ALU_CTRL_EXEC;
      end
      ALU_CTRL_EXEC: begin
        // EXEC is evaluation cycle 1 of a multi-cycle op.
        if (alu_mcp) begin
          state_d = ALU_CTRL_WAIT;
          cnt_d   = mcp_preload(MCP_CYCLES);
        end else begin
          capture = 1'b1;
          state_d = ALU_CTRL_HOLD;
        end
      end
      ALU_CTRL_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ALU_CTRL_HOLD;
        end else begin
          cnt_d = cnt_q - MCP_CNT_W'(1);
        end
      end
      ALU_CTRL_HOLD: begin
        if (res_ready) state_d = accept ? ALU_CTRL_EXEC : ALU_CTRL_IDLE;
      end
      default: state_d = ALU_CTRL_IDLE;
    endcase
    if (flush) begin
      state_d = ALU_CTRL_IDLE;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ALU_CTRL_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wrf_q      <= 1'b0;
      res_data_q <= '0;
      res_qnz_q  <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q  <= issue_opcode;
        a_q   <= issue_a;
        b_q   <= issue_b;
        wrf_q <= issue_wr_flags;
      end
      if (capture) begin
        res_data_q <= alu_dout;
        res_qnz_q  <= alu_qnz;
      end
      // A direct load takes priority over the completing op's flags.
      if (flags_wr) begin
        flag_c_q <= flags_wr_c;
        flag_v_q <= flags_wr_v;
      end else if (capture && wrf_q) begin
        flag_c_q <= alu_cout;
        flag_v_q <= alu_vout;
      end
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cin    = flag_c_q;
  assign alu_vin    = flag_v_q;
  assign res_valid  = (state_q == ALU_CTRL_HOLD);
  assign res_data   = res_data_q;
  assign res_qnz    = res_qnz_q;
  assign flag_c     = flag_c_q;
  assign flag_v     = flag_v_q;
  assign busy       = (state_q != ALU_CTRL_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int MCP = 3;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_a, issue_b;
  logic        issue_wr_flags;
  logic        flush;
  logic        flags_wr, flags_wr_c, flags_wr_v;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic        alu_cin, alu_vin;
  logic [31:0] alu_dout;
  logic        alu_cout, alu_vout, alu_qnz, alu_mcp;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_qnz;
  logic        flag_c, flag_v, busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(32), .OPW(6), .MCP_CYCLES(MCP)) dut (
    .clk(clk), .reset_b(reset_b),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_a(issue_a), .issue_b(issue_b),
    .issue_wr_flags(issue_wr_flags), .flush(flush),
    .flags_wr(flags_wr), .flags_wr_c(flags_wr_c), .flags_wr_v(flags_wr_v),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_vin(alu_vin),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout),
    .alu_qnz(alu_qnz), .alu_mcp(alu_mcp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_qnz(res_qnz), .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
  );

  // Behavioural ALU: plain arithmetic on operands and incoming flags.
  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        nz;
  } alu_res_t;

  function automatic alu_res_t alu_fn(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic ci, input logic vi);
    alu_res_t   r;
    logic [32:0] s;
    r.r = '0; r.c = ci; r.v = vi;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.r = s[31:0]; r.c = s[32];
        r.v = (a[31] == b[31]) && (r.r[31] != a[31]);
      end
      OP_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        r.r = s[31:0]; r.c = s[32];
        r.v = (a[31] == b[31]) && (r.r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r.r = s[31:0]; r.c = ~s[32];
        r.v = (a[31] != b[31]) && (r.r[31] != a[31]);
      end
      OP_AND:  r.r = a & b;
      OP_ASL:  r.r = a << b[4:0];
      OP_MUL:  begin r.r = a * b; r.c = 1'b0; r.v = 1'b0; end
      OP_DJNZ: r.r = a - 32'd1;
      default: r.r = '0;
    endcase
    r.nz = (r.r != 32'd0);
    return r;
  endfunction

  alu_res_t stub;
  always_comb stub = alu_fn(alu_opcode, alu_a, alu_b, alu_cin, alu_vin);
  assign alu_dout = stub.r;
  assign alu_cout = stub.c;
  assign alu_vout = stub.v;
  assign alu_qnz  = stub.nz;
  assign alu_mcp  = (alu_opcode == OP_MUL);

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mc = 1'b0, mv = 1'b0;   // reference architectural flags

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_one(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic wf);
    issue_opcode = op; issue_a = a; issue_b = b; issue_wr_flags = wf; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Single op from IDLE: latency, operand hold, result and flags.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wf, output logic [31:0] got);
    alu_res_t er;
    int       lat, exp_lat;
    er      = alu_fn(op, a, b, mc, mv);
    exp_lat = (op == OP_MUL) ? MCP : 1;
    issue_opcode = op; issue_a = a; issue_b = b; issue_wr_flags = wf;
    issue_valid = 1'b1; res_ready = 1'b0;
    #1 chk("op_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 16) begin
      chk("op_hold_a", alu_a, a);
      chk("op_hold_b", alu_b, b);
      tick();
      lat++;
    end
    chk("op_latency", lat, exp_lat);
    chk("op_data", res_data, er.r);
    chk("op_qnz", res_qnz, er.nz);
    if (wf) begin mc = er.c; mv = er.v; end
    chk("op_flag_c", flag_c, mc);
    chk("op_flag_v", flag_v, mv);
    got = res_data;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("op_release_valid", res_valid, 0);
    chk("op_release_busy", busy, 0);
  endtask

  // Cycle-level stream against a transaction model: one op in flight,
  // result visible `lat` edges after acceptance, freed by the handshake.
  task automatic run_stream(input int n, input int iv_pct, input int rr_pct, input bit b2b);
    logic [5:0]  ops [6];
    logic [5:0]  qop;
    logic [31:0] qa, qb;
    logic        qwf, ewf;
    alu_res_t    er;
    bit          have, pend, exp_valid, exp_ready, cpl, acc;
    int          done, cyc, rem, issued;
    ops = '{OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_DJNZ, OP_MUL};
    have = 0; pend = 0; done = 0; cyc = 0; rem = 0; issued = 0; ewf = 0;
    qop = OP_ADD; qa = '0; qb = '0; qwf = 0; er = '0;
    while (done < n && cyc < 4000) begin
      if (!have && issued < n) begin
        qop = b2b ? OP_ADC : ops[$urandom_range(5)];
        qa  = $urandom; qb = $urandom;
        if ($urandom_range(3) == 0) qa = 32'hFFFF_FFFF;
        qwf = b2b ? 1'b1 : 1'($urandom_range(1));
        have = 1;
      end
      issue_valid = have && ($urandom_range(99) < iv_pct);
      issue_opcode = qop; issue_a = qa; issue_b = qb; issue_wr_flags = qwf;
      res_ready = ($urandom_range(99) < rr_pct);
      #1;
      exp_valid = pend && rem == 0;
      exp_ready = !pend || (exp_valid && res_ready);
      chk("s_ready", issue_ready, exp_ready);
      chk("s_valid", res_valid, exp_valid);
      if (exp_valid) begin
        chk("s_data", res_data, er.r);
        chk("s_qnz", res_qnz, er.nz);
      end
      cpl = exp_valid && res_ready;
      acc = issue_valid && exp_ready;
      tick();
      cyc++;
      if (cpl) begin pend = 0; done++; end
      if (acc) begin
        er = alu_fn(qop, qa, qb, mc, mv);
        ewf = qwf; rem = (qop == OP_MUL) ? MCP : 1;
        pend = 1; have = 0; issued++;
      end else if (pend && rem > 0) begin
        rem--;
        if (rem == 0 && ewf) begin mc = er.c; mv = er.v; end
      end
      chk("s_flag_c", flag_c, mc);
      chk("s_flag_v", flag_v, mv);
    end
    chk("s_done", done, n);
    if (b2b) chk("s_b2b_cycles", cyc, 2 * n + 1);
    issue_valid = 1'b0; res_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    reset_b = 1'b0; issue_valid = 0; issue_opcode = '0; issue_a = '0; issue_b = '0;
    issue_wr_flags = 0; flush = 0; flags_wr = 0; flags_wr_c = 0; flags_wr_v = 0;
    res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_qnz", res_qnz, 0);
    chk("rst_c", flag_c, 0);
    chk("rst_v", flag_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_opcode, 0);
    reset_b = 1'b1;
    tick();

    // ADD with carry-out, then an ADC that consumes it.
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, got);
    chk("add_res", got, 32'h0);
    chk("add_c", flag_c, 1);
    chk("add_v", flag_v, 0);
    chk("add_cin", alu_cin, 1);
    run_op(OP_ADC, 32'h1, 32'h1, 1'b1, got);
    chk("adc_res", got, 32'h3);

    // Multi-cycle MUL.
    run_op(OP_MUL, 32'd6, 32'd7, 1'b1, got);
    chk("mul_res", got, 32'd42);

    // Backpressure on SUB, then a same-edge release and accept.
    res_ready = 1'b0;
    issue_one(OP_SUB, 32'd5, 32'd3, 1'b0);
    tick();
    issue_opcode = OP_ADD; issue_a = 32'd10; issue_b = 32'd20; issue_wr_flags = 0;
    issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 2);
      chk("bp_ready", issue_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    #1 chk("bp_ready_rel", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("b2b_valid", res_valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_alu_a", alu_a, 32'd10);
    tick();
    chk("b2b_res_valid", res_valid, 1);
    chk("b2b_res", res_data, 32'd30);
    tick();
    chk("b2b_idle", busy, 0);
    res_ready = 1'b0;

    // Flush a flag-writing MUL during WAIT.
    flags_wr = 1; flags_wr_c = 1; flags_wr_v = 1;
    tick();
    flags_wr = 0; mc = 1; mv = 1;
    chk("fw_c", flag_c, 1);
    chk("fw_v", flag_v, 1);
    issue_one(OP_MUL, 32'd9, 32'd9, 1'b1);
    tick();
    flush = 1'b1;
    #1 chk("fl_ready", issue_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_valid", res_valid, 0);
    repeat (4) tick();
    chk("fl_valid_late", res_valid, 0);
    chk("fl_c", flag_c, 1);
    chk("fl_v", flag_v, 1);
    // Flush in IDLE blocks acceptance.
    issue_opcode = OP_ADD; issue_valid = 1'b1; flush = 1'b1;
    #1 chk("fl_idle_ready", issue_ready, 0);
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_busy", busy, 0);

    // Direct flag load coincident with capture of a carry-producing ADD.
    issue_one(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    flags_wr = 1; flags_wr_c = 0; flags_wr_v = 1;
    tick();
    flags_wr = 0; mc = 0; mv = 1;
    chk("fwc_valid", res_valid, 1);
    chk("fwc_data", res_data, 0);
    chk("fwc_c", flag_c, 0);
    chk("fwc_v", flag_v, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Asynchronous reset in the middle of a MUL's WAIT phase.
    flags_wr = 1; flags_wr_c = 1; flags_wr_v = 1;
    tick();
    flags_wr = 0;
    issue_one(OP_MUL, 32'd3, 32'd4, 1'b1);
    tick();
    #2 reset_b = 1'b0;
    #1;
    chk("ar_valid", res_valid, 0);
    chk("ar_c", flag_c, 0);
    chk("ar_v", flag_v, 0);
    chk("ar_busy", busy, 0);
    chk("ar_alu_a", alu_a, 0);
    mc = 0; mv = 0;
    @(negedge clk) reset_b = 1'b1;
    tick();

    // Randomized traffic, then full-rate back-to-back flag chaining.
    run_stream(40, 70, 60, 1'b0);
    run_stream(6, 100, 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
